// File: rtl/data_memory_access_unit.sv
// Load/store initiator for the data memory: one request at a time, holds the
// memory enable for WAIT_CYCLES cycles. Optional macro: DMEM_ADDR_RANGE_CHECK_EN.
module data_memory_access_unit #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned MEM_DEPTH   = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_address,
    input  logic [15:0] req_data,
    output logic        resp_valid,
    output logic [15:0] resp_data,
    output logic        resp_fault,
    output logic [15:0] AddressBus,
    output logic [15:0] InputBus,
    input  logic [15:0] OutputBus,
    output logic        sig_enable_write,
    output logic        sig_enable_read
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 4;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    // Reject out-of-range parameter sets at elaboration.
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15 || MEM_DEPTH < 1) begin : g_param_check
        $error("data_memory_access_unit: WAIT_CYCLES must be 1..15 and MEM_DEPTH >= 1");
    end

    logic [1:0]        state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              write_q, write_d;
    logic              req_ready_d;
    logic              resp_valid_d;
    logic              resp_fault_d;
    logic [DATA_W-1:0] resp_data_d;
    logic [DATA_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;
    logic              en_wr_d;
    logic              en_rd_d;
    logic              addr_fault;

`ifdef DMEM_ADDR_RANGE_CHECK_EN
    assign addr_fault = 32'(req_address) >= MEM_DEPTH;
`else
    assign addr_fault = 1'b0;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        write_d      = write_q;
        req_ready_d  = req_ready;
        resp_valid_d = 1'b0;
        resp_fault_d = 1'b0;
        resp_data_d  = resp_data;
        addr_d       = AddressBus;
        wdata_d      = InputBus;
        en_wr_d      = sig_enable_write;
        en_rd_d      = sig_enable_read;

        case (state)
            IDLE: begin
                en_wr_d = 1'b0;
                en_rd_d = 1'b0;
                if (req_valid && req_ready) begin
                    req_ready_d = 1'b0;
                    if (addr_fault) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_fault_d = 1'b1;
                    end else begin
                        state_d = ACCESS;
                        write_d = req_write;
                        addr_d  = req_address;
                        wdata_d = req_data;
                        cnt_d   = CNT_W'(WAIT_CYCLES);
                        en_wr_d = req_write;
                        en_rd_d = !req_write;
                    end
                end
            end
            ACCESS: begin
                cnt_d = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_d      = RESP;
                    en_wr_d      = 1'b0;
                    en_rd_d      = 1'b0;
                    resp_valid_d = 1'b1;
                    if (!write_q) begin
                        resp_data_d = OutputBus;
                    end
                end
            end
            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                en_wr_d     = 1'b0;
                en_rd_d     = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            cnt              <= '0;
            write_q          <= 1'b0;
            req_ready        <= 1'b1;
            resp_valid       <= 1'b0;
            resp_fault       <= 1'b0;
            resp_data        <= '0;
            AddressBus       <= '0;
            InputBus         <= '0;
            sig_enable_write <= 1'b0;
            sig_enable_read  <= 1'b0;
        end else begin
            state            <= state_d;
            cnt              <= cnt_d;
            write_q          <= write_d;
            req_ready        <= req_ready_d;
            resp_valid       <= resp_valid_d;
            resp_fault       <= resp_fault_d;
            resp_data        <= resp_data_d;
            AddressBus       <= addr_d;
            InputBus         <= wdata_d;
            sig_enable_write <= en_wr_d;
            sig_enable_read  <= en_rd_d;
        end
    end

endmodule

// File: tb/tb_data_memory_access_unit.sv
// Self-checking bench for data_memory_access_unit: directed table, hand-written
// back-to-back and reset-abort sequences, then random traffic against a memory model.
module tb_data_memory_access_unit;

    localparam int unsigned WAIT  = 3;
    localparam int unsigned DEPTH = 256;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_address;
    logic [15:0] req_data;
    logic        resp_valid;
    logic [15:0] resp_data;
    logic        resp_fault;
    logic [15:0] AddressBus;
    logic [15:0] InputBus;
    logic [15:0] OutputBus;
    logic        sig_enable_write;
    logic        sig_enable_read;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_accept = 0;

    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];
    logic [15:0] ref_last;

    data_memory_access_unit #(.WAIT_CYCLES(WAIT), .MEM_DEPTH(DEPTH)) dut (
        .clock            (clock),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_address      (req_address),
        .req_data         (req_data),
        .resp_valid       (resp_valid),
        .resp_data        (resp_data),
        .resp_fault       (resp_fault),
        .AddressBus       (AddressBus),
        .InputBus         (InputBus),
        .OutputBus        (OutputBus),
        .sig_enable_write (sig_enable_write),
        .sig_enable_read  (sig_enable_read)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [15:0] init_val(input int i);
        if (i == 0)   return 16'd10;
        if (i == 1)   return 16'd5;
        if (i == 300) return 16'h0BAD;
        return 16'(i * 40503) ^ 16'hA5A5;
    endfunction

    // Memory environment: combinational read, write on enabled edges.
    assign OutputBus = mem[AddressBus];
    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = init_val(i);
        forever begin
            @(posedge clock);
            if (sig_enable_write) mem[AddressBus] = InputBus;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: what the response should carry.
    function automatic void model_step(input logic wr, input logic [15:0] addr,
                                       input logic [15:0] data,
                                       output logic f, output logic [15:0] d);
`ifdef DMEM_ADDR_RANGE_CHECK_EN
        f = (int'(addr) >= int'(DEPTH));
`else
        f = 1'b0;
`endif
        if (f) begin
            d = ref_last;
        end else if (wr) begin
            ref_mem[addr] = data;
            d = ref_last;
        end else begin
            d = ref_mem[addr];
            ref_last = d;
        end
    endfunction

    // Issue one request (called at a falling edge) and watch it to completion.
    task automatic run_txn(input string tag, input logic wr, input logic [15:0] addr,
                           input logic [15:0] data, input logic hold,
                           input logic exp_fault, input logic [15:0] exp_data);
        int wait_n = 0;
        int en_cnt = 0, first_en = 0, wrong_en = 0, bad_bus = 0;
        int resp_cnt = 0, resp_cyc = 0, rdy_cyc = 0, stray_fault = 0;
        logic act_fault = 1'b0;
        logic [15:0] act_data = 16'h0;
        int exp_en;
        req_write = wr; req_address = addr; req_data = data; req_valid = 1'b1;
        while (!req_ready && wait_n < 50) begin
            @(negedge clock);
            wait_n++;
        end
        if (!req_ready) begin
            check({tag, " accept_timeout"}, 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clock);
        last_accept = cyc;
        #1;
        if (!hold) begin
            req_valid = 1'b0; req_address = ~addr; req_data = ~data; req_write = ~wr;
        end
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            if (sig_enable_read || sig_enable_write) begin
                en_cnt++;
                if (first_en == 0) first_en = c;
                if (sig_enable_write !== wr || sig_enable_read !== !wr) wrong_en++;
                if (AddressBus !== addr || (wr && InputBus !== data)) bad_bus++;
            end
            if (resp_valid) begin
                resp_cnt++; resp_cyc = c; act_fault = resp_fault; act_data = resp_data;
            end else if (resp_fault) begin
                stray_fault++;
            end
            if (req_ready) begin
                rdy_cyc = c;
                break;
            end
        end
        exp_en = exp_fault ? 0 : int'(WAIT);
        check({tag, " enable_cycles"}, 32'(en_cnt), 32'(exp_en));
        if (!exp_fault) check({tag, " enable_start"}, 32'(first_en), 32'd1);
        check({tag, " enable_kind"}, 32'(wrong_en), 32'd0);
        check({tag, " bus_values"}, 32'(bad_bus), 32'd0);
        check({tag, " resp_count"}, 32'(resp_cnt), 32'd1);
        check({tag, " resp_cycle"}, 32'(resp_cyc), exp_fault ? 32'd1 : 32'(WAIT + 1));
        check({tag, " resp_fault"}, 32'(act_fault), 32'(exp_fault));
        check({tag, " stray_fault"}, 32'(stray_fault), 32'd0);
        check({tag, " resp_data"}, 32'(act_data), 32'(exp_data));
        check({tag, " ready_cycle"}, 32'(rdy_cyc), exp_fault ? 32'd2 : 32'(WAIT + 2));
        check({tag, " resp_data_held"}, 32'(resp_data), 32'(exp_data));
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
        logic        exp_fault;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    task automatic check_idle_outputs(input string tag, input logic [15:0] exp_rdata);
        check({tag, " req_ready"},  32'(req_ready), 32'd1);
        check({tag, " resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, " resp_fault"}, 32'(resp_fault), 32'd0);
        check({tag, " enables"},    32'({sig_enable_read, sig_enable_write}), 32'd0);
        check({tag, " resp_data"},  32'(resp_data), 32'(exp_rdata));
    endtask

    initial begin
        logic f;
        logic [15:0] d;
        logic wr;
        logic [15:0] a, wd;
        int first_acc;
        int bad;

        for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(i);
        ref_last = 16'h0;

        vecs[0] = '{1'b1, 16'd2,   16'h1234, 1'b0, 16'h0000};
        vecs[1] = '{1'b0, 16'd0,   16'h0000, 1'b0, 16'd10};
        vecs[2] = '{1'b0, 16'd2,   16'h0000, 1'b0, 16'h1234};
        vecs[3] = '{1'b1, 16'd255, 16'hBEEF, 1'b0, 16'h1234};
        vecs[4] = '{1'b0, 16'd255, 16'h0000, 1'b0, 16'hBEEF};
`ifdef DMEM_ADDR_RANGE_CHECK_EN
        vecs[5] = '{1'b0, 16'd300, 16'h0000, 1'b1, 16'hBEEF};
`else
        vecs[5] = '{1'b0, 16'd300, 16'h0000, 1'b0, 16'h0BAD};
`endif

        req_valid = 1'b0; req_write = 1'b0; req_address = 16'h0; req_data = 16'h0;
        reset = 1'b1;
        #1 reset = 1'b0;

        // Reset held low across several edges.
        bad = 0;
        repeat (3) begin
            @(negedge clock);
            if (sig_enable_read || sig_enable_write || resp_valid) bad++;
        end
        check("reset no_activity", 32'(bad), 32'd0);
        check_idle_outputs("reset", 16'h0);
        check("reset buses", {AddressBus, InputBus}, 32'd0);
        reset = 1'b1;
        @(negedge clock);
        check_idle_outputs("post_reset", 16'h0);
        check("post_reset buses", {AddressBus, InputBus}, 32'd0);

        // Directed table.
        for (int i = 0; i < 6; i++) begin
            model_step(vecs[i].wr, vecs[i].addr, vecs[i].data, f, d);
            run_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].data, 1'b0,
                    vecs[i].exp_fault, vecs[i].exp_data);
            @(negedge clock);
        end

        // Back-to-back loads with req_valid held throughout.
        model_step(1'b0, 16'd0, 16'h0, f, d);
        run_txn("b2b_first", 1'b0, 16'd0, 16'h0, 1'b1, 1'b0, 16'd10);
        first_acc = last_accept;
        model_step(1'b0, 16'd1, 16'h0, f, d);
        run_txn("b2b_second", 1'b0, 16'd1, 16'h0, 1'b0, 1'b0, 16'd5);
        check("b2b accept_spacing", 32'(last_accept - first_acc), 32'(WAIT + 2));
        @(negedge clock);

        // Reset asserted during the second enabled cycle of a store.
        req_write = 1'b1; req_address = 16'd7; req_data = 16'h7777; req_valid = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("abort write_enabled", 32'(sig_enable_write), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("abort enables_drop", 32'({sig_enable_read, sig_enable_write}), 32'd0);
        check("abort ready", 32'(req_ready), 32'd1);
        check("abort buses", {AddressBus, InputBus}, 32'd0);
        ref_mem[7] = 16'h7777;
        ref_last = 16'h0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (resp_valid || !req_ready || sig_enable_read || sig_enable_write) bad++;
        end
        check("abort no_response", 32'(bad), 32'd0);
        check_idle_outputs("abort_idle", 16'h0);

        // Random traffic against the reference model.
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(256, 1023));
            else a = 16'($urandom_range(0, 15));
            wd = 16'($urandom);
            model_step(wr, a, wd, f, d);
            run_txn($sformatf("rnd%0d", i), wr, a, wd, 1'b0, f, d);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory_access_unit.md
# data_memory_access_unit

Processor-side initiator for the 256×16 data memory. Accepts one load or store request at a time from the execute stage over a valid/ready handshake. Drives the memory's address, write-data and read/write enable signals for a programmable number of cycles, captures read data, and returns a single-cycle response. It is the only block that drives the data memory's control inputs.

## Interface
Parameters:
- WAIT_CYCLES, 1, cycles the memory enable is held per access; legal range 1..15.
- MEM_DEPTH, 256, number of addressable memory cells; used only by the range check.

Ports:
- clock  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_address  in  16  word address.
- req_data  in  16  store data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_data  out  16  last loaded word.
- resp_fault  out  1  access rejected; see Configuration.
- AddressBus  out  16  memory address.
- InputBus  out  16  memory write data.
- OutputBus  in  16  memory read data.
- sig_enable_write  out  1  memory write enable.
- sig_enable_read  out  1  memory read enable.

## Operation
- FSM states: IDLE, ACCESS, RESP. All outputs are registered.
- IDLE:
  - req_ready=1; all other control outputs 0.
  - Handshake on req_valid && req_ready at a rising edge: latch req_write, req_address and req_data; load the 4-bit counter with WAIT_CYCLES; go to ACCESS.
- ACCESS:
  - req_ready=0.
  - AddressBus and InputBus hold the latched values for the whole state.
  - Exactly one of sig_enable_read or sig_enable_write is 1, per the latched req_write. The two enables are never 1 together.
  - The counter decrements each cycle.
  - On the cycle the counter equals 1:
    - A load captures OutputBus into resp_data.
    - A store leaves resp_data unchanged.
    - Next state is RESP; both enables go to 0 at that edge.
- RESP: resp_valid=1 for exactly one cycle; req_ready=0; next state is IDLE.
- Requests presented while req_ready=0 are ignored. The requester must hold them stable until the handshake.
- AddressBus and InputBus keep their last values in IDLE and RESP; only the enables qualify them.
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - req_ready=1.
  - resp_valid, resp_fault, sig_enable_read and sig_enable_write = 0.
  - resp_data, AddressBus and InputBus = 0.
  - An access in flight is abandoned with no response.

## Timing
- Accept at edge k.
- Enable high during cycles k+1 .. k+WAIT_CYCLES.
- resp_valid high in cycle k+WAIT_CYCLES+1.
- req_ready returns high in cycle k+WAIT_CYCLES+2.
- Maximum throughput: one request per WAIT_CYCLES+2 cycles.
- Load data is sampled from OutputBus at the last enabled edge. resp_data is valid from the resp_valid cycle until the next load completes.
- The fault path (when compiled in) goes IDLE -> RESP directly: resp_valid in cycle k+1.

## Configuration
- Macro: DMEM_ADDR_RANGE_CHECK_EN.
- Defined:
  - At the handshake, req_address >= MEM_DEPTH skips ACCESS entirely; no enable is ever asserted.
  - The FSM goes to RESP with resp_fault=1 for that one cycle; resp_data is unchanged.
  - In-range requests behave as normal, with resp_fault=0.
- Undefined:
  - All addresses are issued to memory unchanged.
  - resp_fault is constant 0.

## Test plan
- Reset, with reset held low then released: every output is 0 except req_ready=1; no enable pulses.
- Store, WAIT_CYCLES=1, store 0x1234 to address 2:
  - sig_enable_write=1 for one cycle with AddressBus=2 and InputBus=0x1234.
  - resp_valid 2 cycles after accept.
  - sig_enable_read stays 0.
- Load, WAIT_CYCLES=1, load address 0 with the memory model returning 10:
  - sig_enable_read=1 for one cycle.
  - resp_data=10 in the resp_valid cycle and held afterward.
- Back-to-back, WAIT_CYCLES=3, req_valid held with two loads (addresses 0 then 1, data 10 then 5):
  - req_ready low for 4 cycles.
  - Second request accepted in the cycle after the first resp_valid.
  - resp_data=10, then 5.
- Reset mid-access, WAIT_CYCLES=3, reset asserted during the second enabled cycle of a store:
  - Enables drop to 0 immediately (asynchronously).
  - No resp_valid.
  - req_ready=1 after release.
- Range check, load address 300:
  - With DMEM_ADDR_RANGE_CHECK_EN: no enable; resp_valid and resp_fault=1 one cycle after accept.
  - Without it: a normal read with AddressBus=300 and resp_fault=0.
